// File: rtl/rv32i_types.sv
// Shared core types: register-file geometry, index typedefs and the
// retirement-RAT recovery FSM encoding.
package rv32i_types;

  localparam int ARCH_REGS  = 32;
  localparam int PREG_WIDTH = 6;

  typedef logic [PREG_WIDTH-1:0] physicalIndexing;
  typedef logic [4:0]            archIndexing;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    REBUILD = 2'd2
  } rrat_state_t;

endpackage

// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys mapping, frees the
// displaced register a cycle after commit, and replays the free list on flush.
module rrat #(
  parameter int ARCH_REGS  = rv32i_types::ARCH_REGS,
  parameter int PREG_WIDTH = rv32i_types::PREG_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  commit_valid,
  input  rv32i_types::archIndexing              commit_rd,
  input  logic [PREG_WIDTH-1:0]                 commit_pd,
  output logic                                  commit_ready,
  input  logic                                  flush_in,
  output logic                                  free_valid,
  output logic [PREG_WIDTH-1:0]                 free_pd,
  output logic                                  rfl_clear_out,
  output logic                                  recover_valid,
  output logic [ARCH_REGS-1:0][PREG_WIDTH-1:0]  recover_map,
  output logic                                  busy_out
);
  import rv32i_types::*;

  localparam int                    PREGS    = 1 << PREG_WIDTH;
  localparam logic [PREG_WIDTH-1:0] IDX_LAST = PREG_WIDTH'(PREGS - 1);

  rrat_state_t                          state_q, state_d;
  logic [PREG_WIDTH-1:0]                idx_q, idx_d;
  logic [ARCH_REGS-1:0][PREG_WIDTH-1:0] map_q, map_d;
  logic [PREGS-1:0]                     mapped_q, mapped_d;
  logic                                 free_valid_q, free_valid_d;
  logic [PREG_WIDTH-1:0]                free_pd_q, free_pd_d;
  logic                                 commit_fire;
  logic [PREG_WIDTH-1:0]                old_pd;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    map_d         = map_q;
    mapped_d      = mapped_q;
    free_valid_d  = 1'b0;
    free_pd_d     = free_pd_q;
    commit_ready  = (state_q == IDLE);
    busy_out      = (state_q != IDLE);
    rfl_clear_out = 1'b0;
    recover_valid = 1'b0;
    free_valid    = free_valid_q;
    free_pd       = free_pd_q;
    recover_map   = map_q;

    commit_fire = commit_valid && commit_ready && (commit_rd != '0);
    old_pd      = map_q[commit_rd];

    // Clear old before setting new so a same-register remap stays mapped.
    if (commit_fire) begin
      map_d[commit_rd]    = commit_pd;
      mapped_d[old_pd]    = 1'b0;
      mapped_d[commit_pd] = 1'b1;
      free_valid_d        = 1'b1;
      free_pd_d           = old_pd;
    end

    case (state_q)
      IDLE: begin
        if (flush_in) state_d = CLEAR;
      end
      CLEAR: begin
        // A free registered in the flush cycle is dropped; REBUILD re-emits it.
        rfl_clear_out = 1'b1;
        recover_valid = 1'b1;
        free_valid    = 1'b0;
        idx_d         = '0;
        state_d       = REBUILD;
      end
      REBUILD: begin
        free_valid = ~mapped_q[idx_q];
        free_pd    = idx_q;
        idx_d      = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the table and bitmap are architectural state, so unlike a data RAM they must be reset.
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mapped_q     <= {{(PREGS - ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
      free_valid_q <= 1'b0;
      free_pd_q    <= '0;
      for (int a = 0; a < ARCH_REGS; a++) map_q[a] <= PREG_WIDTH'(a);
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      map_q        <= map_d;
      mapped_q     <= mapped_d;
      free_valid_q <= free_valid_d;
      free_pd_q    <= free_pd_d;
    end
  end

endmodule
